// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, op-class
// decode helpers and default latencies.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MADD  = 3'd4;
    localparam logic [2:0] MD_MADDU = 3'd5;
    localparam logic [2:0] MD_MSUB  = 3'd6;
    localparam logic [2:0] MD_MSUBU = 3'd7;

    // Op-class bits: bit0 set = unsigned, bit2 set = accumulate into HI/LO.
    localparam int IS_UNSIGNED_BIT = 0;
    localparam int IS_ACC_BIT      = 2;

    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;

    function automatic logic is_div(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

    function automatic logic is_signed(input logic [2:0] op);
        return ~op[IS_UNSIGNED_BIT];
    endfunction

    function automatic logic is_acc(input logic [2:0] op);
        return op[IS_ACC_BIT];
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational datapath: full-width product, quotient/remainder and
// accumulate/subtract against the current HI/LO pair.
module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    logic               sgn;
    logic [2*WIDTH-1:0] ax, bx, prod, acc;
    logic [WIDTH-1:0]   ua, ub, dvs, uq, ur, q, r;

    always_comb begin
        sgn  = is_signed(op);
        ax   = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        bx   = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        // Truncated 2W x 2W product is exact modulo 2^(2W) for both signednesses.
        prod = ax * bx;
        acc  = {hi, lo};

        div_by_zero = is_div(op) && (b == '0);
        ua  = (sgn && a[WIDTH-1]) ? -a : a;
        ub  = (sgn && b[WIDTH-1]) ? -b : b;
        dvs = (ub == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : ub;
        uq  = ua / dvs;
        ur  = ua % dvs;
        // Magnitude divide then re-sign: quotient toward zero, remainder follows dividend.
        q   = (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? -uq : uq;
        r   = (sgn && a[WIDTH-1]) ? -ur : ur;

        case (op)
            MD_MULT, MD_MULTU: result = prod;
            MD_DIV, MD_DIVU:   result = {r, q};
            MD_MADD, MD_MADDU: result = acc + prod;
            default:           result = acc - prod;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: launches an op, holds the result for a fixed
// per-op latency, then commits it to the HI/LO registers.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [2*WIDTH-1:0] calc_res;
    logic               calc_dz;

    md_calc #(.WIDTH(WIDTH)) u_calc (
        .op          (op),
        .a           (a),
        .b           (b),
        .hi          (hi_q),
        .lo          (lo_q),
        .result      (calc_res),
        .div_by_zero (calc_dz)
    );

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        pend_d = pend_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                cnt_d        = '0;
                busy_d       = 1'b0;
                {hi_d, lo_d} = pend_q;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = is_div(op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            // A zero divisor commits the current HI/LO, leaving them unchanged.
            pend_d = calc_dz ? {hi_q, lo_q} : calc_res;
        end else if (hilo_we) begin
            if (hilo_sel) hi_d = wdata;
            else          lo_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            pend_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_md_unit;
    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          hilo_we = 1'b0;
    logic          hilo_sel = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          busy;
    logic [W-1:0]  hi, lo;

    md_unit #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .wdata    (wdata),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference result from the arithmetic definitions, using 64-bit integers.
    function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] x,
                                                 input logic [31:0] y, input logic [31:0] h,
                                                 input logic [31:0] l);
        longint      sx, sy, sq, sr;
        logic [63:0] ux, uy, acc, sp, up;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        acc = {h, l};
        sp  = sx * sy;
        up  = ux * uy;
        case (o)
            3'd0: return sp;
            3'd1: return up;
            3'd2: begin
                if (y == 0) return acc;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sq = sx / sy;
                sr = sx % sy;
                return {sr[31:0], sq[31:0]};
            end
            3'd3: begin
                if (y == 0) return acc;
                return {x % y, x / y};
            end
            3'd4: return acc + sp;
            3'd5: return acc + up;
            3'd6: return acc - sp;
            default: return acc - up;
        endcase
    endfunction

    // Model: an accepted op completes at a deadline edge LAT edges after launch.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;
    bit          m_act = 1'b0;
    int          m_done = 0;
    int          ecount = 0;

    always @(posedge clk) begin
        ecount++;
        if (reset) begin
            m_hi  = '0;
            m_lo  = '0;
            m_act = 1'b0;
        end else if (m_act) begin
            if (ecount == m_done) begin
                {m_hi, m_lo} = m_pend;
                m_act = 1'b0;
            end
        end else if (start) begin
            m_act  = 1'b1;
            m_done = ecount + ((op == 3'd2 || op == 3'd3) ? DL : ML);
            m_pend = model_result(op, a, b, m_hi, m_lo);
        end else if (hilo_we) begin
            if (hilo_sel) m_hi = wdata;
            else          m_lo = wdata;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", {31'd0, busy}, {31'd0, m_act});
            check("model_hi", hi, m_hi);
            check("model_lo", lo, m_lo);
        end
    end

    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout actual=%0d required=<200", n);
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
        launch(o, x, y);
        wait_idle(n);
    endtask

    task automatic mt(input logic sel, input logic [31:0] d);
        hilo_we = 1'b1;
        hilo_sel = sel;
        wdata = d;
        @(negedge clk);
        hilo_we = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        run(3'd0, 32'hFFFF_FFFF, 32'd2, n);
        check("mult_lat", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);
        run(3'd1, 32'hFFFF_FFFF, 32'd2, n);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        run(3'd2, 32'hFFFF_FFF9, 32'd2, n);
        check("div_lat", n, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run(3'd3, 32'd5, 32'd0, n);
        check("divz_lat", n, 32'd10);
        check("divz_hi", hi, 32'hFFFF_FFFF);
        check("divz_lo", lo, 32'hFFFF_FFFD);

        mt(1'b0, 32'd10);
        mt(1'b1, 32'd0);
        run(3'd4, 32'd3, 32'd4, n);
        check("madd_lo", lo, 32'd22);
        check("madd_hi", hi, 32'd0);
        run(3'd7, 32'd23, 32'd1, n);
        check("msubu_hi", hi, 32'hFFFF_FFFF);
        check("msubu_lo", lo, 32'hFFFF_FFFF);

        launch(3'd0, 32'd7, 32'd6);
        @(negedge clk);
        hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'h55;
        start = 1'b1; op = 3'd2; a = 32'd9; b = 32'd3;
        @(negedge clk);
        hilo_we = 1'b0;
        start = 1'b0;
        wait_idle(n);
        check("busyign_rest", n, 32'd3);
        check("busyign_lo", lo, 32'd42);
        check("busyign_hi", hi, 32'd0);
        @(negedge clk);
        check("busyign_lo_after", lo, 32'd42);

        launch(3'd2, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_hi", hi, 32'd0);
        check("rstmid_lo", lo, 32'd0);
        repeat (15) @(negedge clk);
        check("rstmid_late_hi", hi, 32'd0);
        check("rstmid_late_lo", lo, 32'd0);

        start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd8;
        hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'h55;
        @(negedge clk);
        start = 1'b0;
        hilo_we = 1'b0;
        check("startwe_busy", {31'd0, busy}, 32'd1);
        check("startwe_lo_drop", lo, 32'd0);
        wait_idle(n);
        check("startwe_lat", n, 32'd5);
        check("startwe_lo", lo, 32'd56);

        start = 1'b1; reset = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check("rststart_busy", {31'd0, busy}, 32'd0);
        repeat (8) @(negedge clk);
        check("rststart_lo", lo, 32'd0);

        run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check("divmin_lo", lo, 32'h8000_0000);
        check("divmin_hi", hi, 32'd0);
        run(3'd1, 32'd2, 32'd3, n);
        check("b2b_lat", n, 32'd5);
        check("b2b_lo", lo, 32'd6);
        check("b2b_hi", hi, 32'd0);

        repeat (800) begin
            reset    = ($urandom % 64) == 0;
            start    = ($urandom % 3) == 0;
            op       = 3'($urandom % 8);
            a        = pick();
            b        = pick();
            hilo_we  = ($urandom % 4) == 0;
            hilo_sel = 1'($urandom % 2);
            wdata    = $urandom;
            @(negedge clk);
        end
        reset = 1'b0;
        start = 1'b0;
        hilo_we = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
